// File: rtl/stream_packet_tx_pkg.sv
// Shared definitions for the length-prefixed stream framer and its consumers.
package stream_packet_tx_pkg;

  // Default stream word width; also the width of the header length field.
  localparam int DATA_W_DEFAULT = 16;

  // Framer state encoding; the input bridge decodes the same values.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    FIN  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with a combinational head read.
// The head entry sits at rd_ptr and changes only on a pop, so a downstream
// holder of the head sees a stable word until it consumes it.
module sync_fifo
  import stream_packet_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt state.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage write; a write never targets the head slot while it holds live data.
  // NOTE: the storage array is deliberately not reset; count alone marks which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/stream_packet_tx.sv
// Master-side AXI-Stream packet framer: one header word carrying the payload
// length N, then N payload words drained from an internal FIFO, TLAST on the
// final word. A local producer fills the FIFO at any time, including mid-packet.
module stream_packet_tx
  import stream_packet_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                M_AXIS_ACLK,
  input  logic                M_AXIS_ARESET,
  input  logic [DATA_W-1:0]   load_data,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic                start,
  input  logic [DATA_W-1:0]   start_len,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     fifo_count,
  output logic                M_AXIS_TVALID,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
  output logic                M_AXIS_TLAST,
  input  logic                M_AXIS_TREADY
);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign load_ready = !fifo_full;
  assign push       = load_valid && !fifo_full;
  assign pop        = M_AXIS_TVALID && M_AXIS_TREADY && (state_q == DATA);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (M_AXIS_ACLK),
    .rst     (M_AXIS_ARESET),
    .push    (push),
    .pop     (pop),
    .wr_data (load_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State and remaining-length registers; reset abandons any partial packet.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state, length countdown and stream outputs for the framer.
  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = start_len;
          state_d     = HDR;
        end
      end
      HDR: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = remaining_q;
        M_AXIS_TLAST  = (remaining_q == '0);
        if (M_AXIS_TREADY) state_d = (remaining_q == '0) ? FIN : DATA;
      end
      DATA: begin
        // Stall with TVALID low while the producer refills the FIFO.
        M_AXIS_TVALID = !fifo_empty;
        M_AXIS_TDATA  = fifo_empty ? '0 : fifo_head;
        M_AXIS_TLAST  = !fifo_empty && (remaining_q == DATA_W'(1));
        if (!fifo_empty && M_AXIS_TREADY) begin
          remaining_d = remaining_q - DATA_W'(1);
          if (remaining_q == DATA_W'(1)) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign M_AXIS_TKEEP = {(DATA_W/8){M_AXIS_TVALID}};
  assign busy         = (state_q == HDR) || (state_q == DATA);
  assign done         = (state_q == FIN);

endmodule
